// File: rtl/psk_demodulator_pkg.sv
// Shared PSK definitions: receiver state encoding, default link parameters
// and the counter-width helper used by psk_demodulator and the modulator.
package psk_demodulator_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RECEIVE = 1'b1
    } psk_state_t;

    localparam int PSK_CLKS_PER_BIT    = 4;
    localparam int PSK_BITS_PER_SYMBOL = 4;
    localparam int PSK_REPEAT          = 30;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/psk_bit_timer.sv
// Clock/bit position tracker for one received symbol; flags the sampling
// clock of each bit and the last clock of the symbol.
module psk_bit_timer
    import psk_demodulator_pkg::*;
#(
    parameter int  CLKS_PER_BIT    = PSK_CLKS_PER_BIT,
    parameter int  BITS_PER_SYMBOL = PSK_BITS_PER_SYMBOL,
    localparam int CW              = cnt_width(CLKS_PER_BIT),
    localparam int BW              = cnt_width(BITS_PER_SYMBOL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic          run,
    output logic          sample_strobe,
    output logic          symbol_end,
    output logic [BW-1:0] bit_idx
);

    localparam logic [CW-1:0] CLK_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_SAMPLE = CW'(CLKS_PER_BIT / 2);
    localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_SYMBOL - 1);

    logic [CW-1:0] clk_cnt;
    logic [BW-1:0] bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else if (restart) begin
            // the restart cycle itself is clock 0 of bit 0, so the next one is clock 1
            clk_cnt <= CW'(1);
            bit_cnt <= '0;
        end else if (run) begin
            if (clk_cnt == CLK_LAST) begin
                clk_cnt <= '0;
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
        end
    end

    assign sample_strobe = run && (clk_cnt == CLK_SAMPLE);
    assign symbol_end    = run && (clk_cnt == CLK_LAST) && (bit_cnt == BIT_LAST);
    assign bit_idx       = bit_cnt;

endmodule

// File: rtl/psk_demodulator.sv
// Repetition-coded serial receiver: assembles REPEAT+1 copies of each symbol,
// flags copy disagreement and writes the first copy into a downstream FIFO.
module psk_demodulator
    import psk_demodulator_pkg::*;
#(
    parameter int PARAMETER01 = PSK_CLKS_PER_BIT,
    parameter int PARAMETER02 = PSK_BITS_PER_SYMBOL,
    parameter int PARAMETER04 = PSK_REPEAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       serial_in,
    input  logic       nsync,
    input  logic       full,
    output logic [7:0] data,
    output logic       write,
    output logic       overflow,
    output logic       mismatch,
    output logic       symb_clk
);

    localparam int             BW        = cnt_width(PARAMETER02);
    localparam int             RW        = cnt_width(PARAMETER04 + 1);
    localparam logic [RW-1:0]  COPY_LAST = RW'(PARAMETER04);

    psk_state_t    state, state_next;
    logic          restart, run;
    logic          sample_strobe, symbol_end;
    logic [BW-1:0] bit_idx;
    logic [RW-1:0] copy_cnt;
    logic [7:0]    sym_q, sym_cur, ref_sym, ref_cur;

    psk_bit_timer #(
        .CLKS_PER_BIT   (PARAMETER01),
        .BITS_PER_SYMBOL(PARAMETER02)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .restart      (restart),
        .run          (run),
        .sample_strobe(sample_strobe),
        .symbol_end   (symbol_end),
        .bit_idx      (bit_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        restart    = 1'b0;
        run        = 1'b0;
        if (enable) begin
            case (state)
                ST_IDLE: begin
                    if (!nsync) begin
                        restart    = 1'b1;
                        state_next = ST_RECEIVE;
                    end
                end
                ST_RECEIVE: begin
                    if (!nsync) restart = 1'b1;
                    else        run     = 1'b1;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // the last bit may be sampled on the symbol-end clock, so merge it in here
    always_comb begin
        sym_cur = sym_q;
        if (sample_strobe) sym_cur[bit_idx] = serial_in;
        ref_cur = (copy_cnt == '0) ? sym_cur : ref_sym;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            copy_cnt <= '0;
            sym_q    <= '0;
            ref_sym  <= '0;
            data     <= '0;
            write    <= 1'b0;
            overflow <= 1'b0;
            mismatch <= 1'b0;
            symb_clk <= 1'b0;
        end else begin
            write <= 1'b0;
            if (restart) begin
                copy_cnt <= '0;
            end else begin
                if (sample_strobe) sym_q <= sym_cur;
                if (symbol_end) begin
                    symb_clk <= ~symb_clk;
                    if (copy_cnt == '0)          ref_sym  <= sym_cur;
                    else if (sym_cur != ref_sym) mismatch <= 1'b1;
                    if (copy_cnt == COPY_LAST) begin
                        copy_cnt <= '0;
                        if (full) begin
                            overflow <= 1'b1;
                        end else begin
                            data  <= ref_cur;
                            write <= 1'b1;
                        end
                    end else begin
                        copy_cnt <= copy_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_psk_demodulator.sv
// Bench for psk_demodulator: two configurations (8-bit x3 copies, 4-bit x1)
// checked every cycle against a symbol-level model plus literal write logs.
module tb_psk_demodulator;

    localparam int C = 4;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] en_i, ns_i, ser_i, full_i;
    logic [7:0] data_a, data_b;
    logic wr_a, wr_b, ov_a, ov_b, mm_a, mm_b, sc_a, sc_b;
    logic [1:0]      wr_o, ov_o, mm_o, sc_o;
    logic [1:0][7:0] data_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_on  = 1'b0;

    logic [7:0] ev_wr [int];
    bit         ev_mm [int];
    bit         ev_ov [int];
    bit         ev_tg [int];
    logic [1:0]      exp_mm, exp_ov, exp_sc;
    logic [1:0][7:0] exp_data;

    typedef struct { int sel; int c; logic [7:0] d; } wr_rec_t;
    wr_rec_t wr_log [$];
    wr_rec_t rec;

    psk_demodulator #(.PARAMETER01(C), .PARAMETER02(8), .PARAMETER04(2)) dut_a (
        .clk(clk), .rst(rst), .enable(en_i[0]), .serial_in(ser_i[0]), .nsync(ns_i[0]),
        .full(full_i[0]), .data(data_a), .write(wr_a), .overflow(ov_a),
        .mismatch(mm_a), .symb_clk(sc_a));

    psk_demodulator #(.PARAMETER01(C), .PARAMETER02(4), .PARAMETER04(0)) dut_b (
        .clk(clk), .rst(rst), .enable(en_i[1]), .serial_in(ser_i[1]), .nsync(ns_i[1]),
        .full(full_i[1]), .data(data_b), .write(wr_b), .overflow(ov_b),
        .mismatch(mm_b), .symb_clk(sc_b));

    assign wr_o   = {wr_b, wr_a};
    assign ov_o   = {ov_b, ov_a};
    assign mm_o   = {mm_b, mm_a};
    assign sc_o   = {sc_b, sc_a};
    assign data_o = {data_b, data_a};

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int sel, input logic [31:0] act,
                         input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, sel, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int s = 0; s < 2; s++) begin
                int   key;
                logic want_w;
                key    = cyc * 2 + s;
                want_w = (ev_wr.exists(key) != 0);
                if (want_w)              exp_data[s] = ev_wr[key];
                if (ev_mm.exists(key) != 0) exp_mm[s] = 1'b1;
                if (ev_ov.exists(key) != 0) exp_ov[s] = 1'b1;
                if (ev_tg.exists(key) != 0) exp_sc[s] = ~exp_sc[s];
                check("write",    s, 32'(wr_o[s]),   32'(want_w));
                check("data",     s, 32'(data_o[s]), 32'(exp_data[s]));
                check("mismatch", s, 32'(mm_o[s]),   32'(exp_mm[s]));
                check("overflow", s, 32'(ov_o[s]),   32'(exp_ov[s]));
                check("symb_clk", s, 32'(sc_o[s]),   32'(exp_sc[s]));
                if (wr_o[s] === 1'b1) begin
                    rec.sel = s;
                    rec.c   = cyc;
                    rec.d   = data_o[s];
                    wr_log.push_back(rec);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic en, input logic ns, input logic ser,
                         input logic fl);
        en_i[sel]   = en;
        ns_i[sel]   = ns;
        ser_i[sel]  = ser;
        full_i[sel] = fl;
    endtask

    task automatic do_rst();
        rst      = 1'b1;
        exp_mm   = '0;
        exp_ov   = '0;
        exp_sc   = '0;
        exp_data = '0;
        #3;
        rst = 1'b0;
    endtask

    // One set of copies: model schedules the visible effects of every symbol end,
    // then the stream is driven with the correct bit only on the sampling clock.
    task automatic send_set(input int sel, input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input bit sync, input bit full_end,
                            input int freeze_pos, input int freeze_len, input int stop_pos);
        int         nb, nr, bc, total, s, pend, t, key, j, b, c;
        logic [7:0] cp [3];
        logic [7:0] mask;
        logic       bitv;
        nb    = (sel == 0) ? 8 : 4;
        nr    = (sel == 0) ? 2 : 0;
        bc    = nb * C;
        total = (nr + 1) * bc;
        cp[0] = c0; cp[1] = c1; cp[2] = c2;
        mask  = 8'((1 << nb) - 1);
        s     = cyc;
        for (int k = 0; k <= nr; k++) begin
            pend = (k + 1) * bc - 1;
            if (stop_pos >= 0 && pend >= stop_pos) break;
            t   = s + pend + 1 + ((freeze_pos >= 0 && freeze_pos <= pend) ? freeze_len : 0);
            key = t * 2 + sel;
            ev_tg[key] = 1'b1;
            if (k >= 1 && (cp[k] & mask) != (cp[0] & mask)) ev_mm[key] = 1'b1;
            if (k == nr) begin
                if (full_end) ev_ov[key] = 1'b1;
                else          ev_wr[key] = cp[0] & mask;
            end
        end
        for (int p = 0; p < total; p++) begin
            if (p == stop_pos) break;
            j    = p / bc;
            b    = (p % bc) / C;
            c    = p % C;
            bitv = cp[j][b];
            if (p == freeze_pos) begin
                for (int f = 0; f < freeze_len; f++) begin
                    drive(sel, 1'b0, 1'b0, ~bitv, 1'b0);
                    step();
                end
            end
            drive(sel, 1'b1, !(sync && p == 0), (c == C / 2) ? bitv : ~bitv,
                  full_end && (p == total - 1));
            step();
        end
    endtask

    task automatic expect_log(input int sel, input int want_c, input logic [7:0] want_d);
        wr_rec_t r;
        if (wr_log.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL write_log dut%0d got=none want=%0h@%0d", sel, want_d, want_c);
        end else begin
            r = wr_log.pop_front();
            check("log_dut",   sel, 32'(r.sel), 32'(sel));
            check("log_cycle", sel, 32'(r.c),   32'(want_c));
            check("log_data",  sel, 32'(r.d),   32'(want_d));
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_data",     0, 32'(data_a), 32'h00);
        check("rst_write",    0, 32'(wr_a),   32'h0);
        check("rst_overflow", 0, 32'(ov_a),   32'h0);
        check("rst_mismatch", 0, 32'(mm_a),   32'h0);
        check("rst_symb_clk", 0, 32'(sc_a),   32'h0);
    endtask

    initial begin
        int t0, t1;
        rst      = 1'b1;
        en_i     = '0;
        ns_i     = '1;
        ser_i    = '0;
        full_i   = '0;
        exp_mm   = '0;
        exp_ov   = '0;
        exp_sc   = '0;
        exp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_on = 1'b1;
        step();
        check_reset_outputs();

        // 4-bit, no repetition: 9 then 6 back-to-back, writes 16 clocks apart
        wr_log.delete();
        t0 = cyc;
        send_set(1, 8'hF9, 8'h00, 8'h00, 1'b1, 1'b0, -1, 0, -1);
        send_set(1, 8'hE6, 8'h00, 8'h00, 1'b0, 1'b0, -1, 0, -1);
        drive(1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        expect_log(1, t0 + 16, 8'h09);
        expect_log(1, t0 + 32, 8'h06);

        // three clean copies of A5: write 96 clocks after nsync
        wr_log.delete();
        t0 = cyc;
        send_set(0, 8'hA5, 8'hA5, 8'hA5, 1'b1, 1'b0, -1, 0, -1);
        drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        expect_log(0, t0 + 96, 8'hA5);
        check("a5_mismatch", 0, 32'(mm_a), 32'h0);

        // differing middle copy: first copy written, mismatch sticky until rst
        wr_log.delete();
        t0 = cyc;
        send_set(0, 8'h3C, 8'h3D, 8'h3C, 1'b1, 1'b0, -1, 0, -1);
        drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) step();
        expect_log(0, t0 + 96, 8'h3C);
        check("mm_held", 0, 32'(mm_a), 32'h1);
        do_rst();
        step();
        check("mm_cleared", 0, 32'(mm_a), 32'h0);

        // full at the final copy end drops the byte; the next byte goes through
        wr_log.delete();
        t0 = cyc;
        send_set(0, 8'h11, 8'h11, 8'h11, 1'b1, 1'b1, -1, 0, -1);
        send_set(0, 8'h22, 8'h22, 8'h22, 1'b0, 1'b0, -1, 0, -1);
        drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("ovf_held", 0, 32'(ov_a), 32'h1);
        expect_log(0, t0 + 192, 8'h22);
        check("ovf_writes", 0, 32'(wr_log.size()), 32'h0);

        // nsync at bit 5 of copy 1 aborts the set; the restarted set writes once
        do_rst();
        step();
        wr_log.delete();
        send_set(0, 8'h81, 8'h81, 8'h81, 1'b1, 1'b0, -1, 0, 52);
        t1 = cyc;
        send_set(0, 8'h81, 8'h81, 8'h81, 1'b1, 1'b0, -1, 0, -1);
        drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        expect_log(0, t1 + 96, 8'h81);
        check("abort_writes", 0, 32'(wr_log.size()), 32'h0);

        // 7-clock freeze on a sampling clock, then rst mid-symbol
        wr_log.delete();
        t0 = cyc;
        send_set(0, 8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0, 14, 7, -1);
        send_set(0, 8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0, -1, 0, 40);
        do_rst();
        for (int i = 0; i < 100; i++) begin
            drive(0, 1'b1, 1'b1, 1'(i % 2), 1'b0);
            step();
        end
        expect_log(0, t0 + 103, 8'h5A);
        check("post_rst_writes", 0, 32'(wr_log.size()), 32'h0);
        check_reset_outputs();

        wr_log.delete();
        t0 = cyc;
        send_set(0, 8'hC3, 8'hC3, 8'hC3, 1'b1, 1'b0, -1, 0, -1);
        drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        expect_log(0, t0 + 96, 8'hC3);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
